// File: rtl/ospfb_ctrl.sv
// Sequencing controller for the oversampled PFB: frame counter, load/loop select,
// coefficient addressing, per-frame phase-compensation rotation and FIR fill gating.
module ospfb_ctrl #(
  parameter int FFT_LEN = 64,
  parameter int DEC_FAC = 48,
  parameter int PTAPS   = 8,
  parameter int AW      = $clog2(FFT_LEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          s_tvalid,
  output logic          s_tready,
  input  logic          m_tready,
  output logic          pipe_en,
  output logic          load_sel,
  output logic [AW-1:0] coeff_addr,
  output logic          frame_start,
  output logic          frame_last,
  output logic [AW-1:0] pc_shift,
  output logic          m_tvalid
);

  localparam int            FW       = $clog2(PTAPS + 1);
  localparam logic [AW:0]   DEC_EXT  = (AW+1)'(DEC_FAC);
  localparam logic [AW:0]   LEN_EXT  = (AW+1)'(FFT_LEN);
  localparam logic [AW-1:0] LAST     = AW'(FFT_LEN - 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(PTAPS);

  logic [1:0]    rst_sync;
  logic          run_ok;
  logic [AW-1:0] cyc;
  logic [FW-1:0] fill;
  logic [AW:0]   pc_sum;
  logic [AW-1:0] pc_next;

  // Reset assertion is immediate; release reaches the handshake logic two edges later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign run_ok = rst_sync[1];

  assign load_sel    = ({1'b0, cyc} < DEC_EXT);
  assign coeff_addr  = cyc;
  assign frame_start = (cyc == '0);
  assign frame_last  = (cyc == LAST);

  assign pipe_en  = run_ok & en & m_tready & (~load_sel | s_tvalid);
  assign s_tready = run_ok & en & m_tready & load_sel;
  assign m_tvalid = pipe_en & (fill == FILL_MAX);

  // Rotation advances by D each frame, reduced modulo M with one conditional subtract.
  always_comb begin
    pc_sum  = {1'b0, pc_shift} + DEC_EXT;
    pc_next = pc_sum[AW-1:0];
    if (pc_sum >= LEN_EXT) begin
      pc_next = AW'(pc_sum - LEN_EXT);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc      <= '0;
      pc_shift <= '0;
      fill     <= '0;
    end else if (pipe_en) begin
      cyc <= frame_last ? '0 : cyc + 1'b1;
      if (frame_last) begin
        pc_shift <= pc_next;
        if (fill < FILL_MAX) begin
          fill <= fill + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ospfb_ctrl.sv
// Directed testbench for ospfb_ctrl with M=8, D=6, PTAPS=3 and a small behavioural model.
module tb_ospfb_ctrl;

  localparam int M  = 8;
  localparam int D  = 6;
  localparam int P  = 3;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b1;
  logic          s_tvalid = 1'b1;
  logic          m_tready = 1'b1;
  logic          s_tready;
  logic          pipe_en;
  logic          load_sel;
  logic [AW-1:0] coeff_addr;
  logic          frame_start;
  logic          frame_last;
  logic [AW-1:0] pc_shift;
  logic          m_tvalid;

  int errors = 0;
  int checks = 0;

  int e_cyc = 0;
  int e_pc = 0;
  int e_fill = 0;
  int sync_cnt = 0;
  bit in_reset = 1'b1;
  int adv_count = 0;
  int first_mv = -1;
  int f = 0;
  int pc_tab[5] = '{0, 6, 4, 2, 0};

  ospfb_ctrl #(.FFT_LEN(M), .DEC_FAC(D), .PTAPS(P)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .s_tvalid(s_tvalid),
    .s_tready(s_tready),
    .m_tready(m_tready),
    .pipe_en(pipe_en),
    .load_sel(load_sel),
    .coeff_addr(coeff_addr),
    .frame_start(frame_start),
    .frame_last(frame_last),
    .pc_shift(pc_shift),
    .m_tvalid(m_tvalid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic bit expOk();
    return !in_reset && (sync_cnt >= 2);
  endfunction

  function automatic bit expPipe();
    return expOk() && en && m_tready && ((e_cyc >= D) || s_tvalid);
  endfunction

  task automatic checkOutput();
    bit e_load;
    e_load = (e_cyc < D);
    chk("load_sel",    8'(load_sel),    8'(e_load));
    chk("coeff_addr",  8'(coeff_addr),  8'(e_cyc));
    chk("frame_start", 8'(frame_start), 8'(e_cyc == 0));
    chk("frame_last",  8'(frame_last),  8'(e_cyc == M-1));
    chk("pc_shift",    8'(pc_shift),    8'(e_pc));
    chk("pipe_en",     8'(pipe_en),     8'(expPipe()));
    chk("s_tready",    8'(s_tready),    8'(expOk() && en && m_tready && e_load));
    chk("m_tvalid",    8'(m_tvalid),    8'(expPipe() && (e_fill == P)));
    if (m_tvalid === 1'b1 && first_mv < 0) first_mv = adv_count;
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are checked on the falling edge.
  task automatic applyStimulus(input logic sv, input logic mr, input logic e);
    bit adv;
    s_tvalid = sv;
    m_tready = mr;
    en = e;
    @(negedge clk);
    checkOutput();
    adv = expPipe();
    @(posedge clk);
    if (adv) begin
      adv_count++;
      if (e_cyc == M-1) begin
        e_cyc = 0;
        e_pc = (e_pc + D) % M;
        if (e_fill < P) e_fill++;
      end else begin
        e_cyc++;
      end
    end
    if (!in_reset && sync_cnt < 2) sync_cnt++;
    #1;
  endtask

  task automatic runTo(input int target);
    for (int i = 0; i < 3*M && e_cyc != target; i++) applyStimulus(1'b1, 1'b1, 1'b1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    $display("[TB] reset state");
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    rst = 1'b1;
    in_reset = 1'b0;
    sync_cnt = 0;

    $display("[TB] free run");
    for (int i = 0; i < 42; i++) begin
      if (sync_cnt >= 2 && e_cyc == 0 && f < 5) begin
        chk("pc_frame", 8'(pc_shift), 8'(pc_tab[f]));
        f++;
      end
      applyStimulus(1'b1, 1'b1, 1'b1);
    end
    chk("first_mvalid", 8'(first_mv), 8'd24);

    $display("[TB] input underflow at cyc 2");
    runTo(2);
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b1);
    chk("uf_hold_addr", 8'(coeff_addr), 8'd2);
    runTo(0);
    applyStimulus(1'b1, 1'b1, 1'b1);

    $display("[TB] underflow on loop cycles");
    runTo(6);
    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    chk("loop_uf_wrap", 8'(coeff_addr), 8'd0);

    $display("[TB] backpressure across frame boundary");
    runTo(7);
    repeat (5) applyStimulus(1'b1, 1'b0, 1'b1);
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b1);

    $display("[TB] enable toggling");
    runTo(3);
    repeat (10) applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (12) applyStimulus(1'b1, 1'b1, 1'b1);

    $display("[TB] reset mid-operation");
    for (int i = 0; i < 5*M && !(e_cyc == 5 && e_fill == P); i++) applyStimulus(1'b1, 1'b1, 1'b1);
    chk("pre_reset_mv", 8'(m_tvalid), 8'd1);
    rst = 1'b0;
    in_reset = 1'b1;
    e_cyc = 0;
    e_pc = 0;
    e_fill = 0;
    #1;
    checkOutput();
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_reset = 1'b0;
    sync_cnt = 0;
    adv_count = 0;
    first_mv = -1;
    repeat (34) applyStimulus(1'b1, 1'b1, 1'b1);
    chk("mv_after_reset", 8'(first_mv), 8'd24);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
